// File: rtl/gups_rmw_engine.sv
// gups_rmw_engine: LFSR-addressed read-modify-write updater with GUPS performance counters
module gups_rmw_engine #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32,
  parameter int CYC_W  = 48,
  parameter int WARMUP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [63:0]       seed,
  input  logic [CNT_W-1:0]  num_updates,
  input  logic [ADDR_W-1:0] range_mask,
  input  logic              mode,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  updates_done,
  output logic [CYC_W-1:0]  cycles
);
  typedef enum logic [2:0] {IDLE, WARM, CHECK, RD, RWAIT, WR, FIN} state_t;
  state_t              state;
  logic [63:0]         lfsr;
  logic [63:0]         lfsr_nxt;
  logic [CNT_W-1:0]    num_q;
  logic [ADDR_W-1:0]   mask_q;
  logic                mode_q;
  logic [3:0]          warm_cnt;
  assign lfsr_nxt = {1'b0, lfsr[63:1]} ^ (lfsr[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  // Run control: one update is RD -> RWAIT -> WR -> CHECK, all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      lfsr         <= 64'h1;
      num_q        <= '0;
      mask_q       <= '0;
      mode_q       <= 1'b0;
      warm_cnt     <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      updates_done <= '0;
      cycles       <= '0;
    end else begin
      done <= 1'b0;
      if (busy && cycles != '1) cycles <= cycles + 1'b1;
      case (state)
        IDLE: if (start) begin
          lfsr         <= (seed == 64'h0) ? 64'h1 : seed;
          num_q        <= num_updates;
          mask_q       <= range_mask;
          mode_q       <= mode;
          warm_cnt     <= '0;
          updates_done <= '0;
          cycles       <= '0;
          busy         <= 1'b1;
          state        <= WARM;
        end
        WARM: if (warm_cnt == 4'(WARMUP)) state <= CHECK;
        else begin
          lfsr     <= lfsr_nxt;
          warm_cnt <= warm_cnt + 1'b1;
        end
        CHECK: if (updates_done == num_q) state <= FIN;
        else begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= lfsr[ADDR_W-1:0] & mask_q;
          state    <= RD;
        end
        RD: if (mem_gnt) begin
          mem_req <= 1'b0;
          state   <= RWAIT;
        end
        RWAIT: if (mem_rvalid) begin
          mem_wdata <= mode_q ? (mem_rdata ^ lfsr[DATA_W-1:0]) : (mem_rdata + 1'b1);
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          state     <= WR;
        end
        WR: if (mem_gnt) begin
          mem_req      <= 1'b0;
          mem_we       <= 1'b0;
          updates_done <= updates_done + 1'b1;
          lfsr         <= lfsr_nxt;
          state        <= CHECK;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gups_rmw_engine.sv
// tb_gups_rmw_engine: directed checks of gups_rmw_engine against a memory responder and reference GUPS
module tb_gups_rmw_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] seed = '0;
  logic [31:0] num_updates = '0;
  logic [31:0] range_mask = '0;
  logic        mode = 1'b0;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy, done;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [31:0] updates_done;
  logic [47:0] cycles;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] mem [256];
  logic [63:0] ref_mem [256];
  int          rd_log[$];
  int          wa_log[$];
  logic [63:0] wd_log[$];
  int          max_stall = 0;
  bit          hold_wr = 1'b0;
  int          stab_err = 0;
  logic [23:0] hi_seen = '0;
  int          first_req, done_at;

  gups_rmw_engine #(.ADDR_W(32), .DATA_W(64), .CNT_W(32), .CYC_W(48), .WARMUP(0)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .num_updates(num_updates),
    .range_mask(range_mask), .mode(mode), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .updates_done(updates_done), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rd_at(input int i);
    return (i < rd_log.size()) ? rd_log[i] : -1;
  endfunction

  function automatic int wa_at(input int i);
    return (i < wa_log.size()) ? wa_log[i] : -1;
  endfunction

  function automatic logic [63:0] wd_at(input int i);
    return (i < wd_log.size()) ? wd_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] step(input logic [63:0] l);
    return {1'b0, l[63:1]} ^ (l[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  // Memory responder: random gnt/rvalid latency, checks request stability under stall
  initial begin
    int          wait_left, rv_wait, rd_a;
    bit          pend, sv;
    logic [31:0] s_addr;
    logic        s_we;
    logic [63:0] s_wd;
    wait_left = -1; rv_wait = 0; rd_a = 0; pend = 0; sv = 0;
    s_addr = '0; s_we = 0; s_wd = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 0;
      mem_rvalid = 0;
      if (!reset) begin
        pend = 0; sv = 0; wait_left = -1;
      end else begin
        if (sv && mem_req && (mem_addr !== s_addr || mem_we !== s_we || (mem_we && mem_wdata !== s_wd)))
          stab_err++;
        sv = 0;
        if (pend) begin
          if (rv_wait == 0) begin
            mem_rvalid = 1; mem_rdata = mem[rd_a]; pend = 0;
          end else rv_wait--;
        end
        if (mem_req && !(mem_we && hold_wr)) begin
          if (wait_left < 0) wait_left = int'($urandom_range(max_stall, 0));
          if (wait_left == 0) begin
            mem_gnt = 1;
            wait_left = -1;
            hi_seen |= mem_addr[31:8];
            if (mem_we) begin
              mem[mem_addr[7:0]] = mem_wdata;
              wa_log.push_back(int'(mem_addr));
              wd_log.push_back(mem_wdata);
            end else begin
              pend = 1;
              rd_a = int'(mem_addr[7:0]);
              rv_wait = int'($urandom_range(max_stall, 0));
              rd_log.push_back(int'(mem_addr));
            end
          end else wait_left--;
        end
        if (mem_req && !mem_gnt) begin
          sv = 1; s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata;
        end
      end
    end
  end

  task automatic run(input logic [63:0] s, input logic [31:0] n, input logic [31:0] m,
                     input logic md, input int budget);
    rd_log.delete(); wa_log.delete(); wd_log.delete(); hi_seen = '0;
    @(negedge clk);
    seed = s; num_updates = n; range_mask = m; mode = md; start = 1;
    @(negedge clk);
    start = 0;
    first_req = -1;
    done_at = -1;
    for (int k = 0; k < budget && done_at < 0; k++) begin
      if (mem_req && first_req < 0) first_req = k;
      if (done) done_at = k;
      else @(negedge clk);
    end
    chk("done_seen", 64'(done_at >= 0), 1);
  endtask

  initial begin
    int mis, sum;
    logic [63:0] l;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_upd", updates_done, 0);
    chk("rst_cyc", cycles, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    reset = 1;
    // single INC update, best-case latency
    mem[1] = 7;
    run(64'h1, 1, 32'hFF, 0, 100);
    chk("t1_first_req", first_req, 2);
    chk("t1_done_at", done_at, 7);
    chk("t1_rd_addr", rd_at(0), 1);
    chk("t1_wr_addr", wa_at(0), 1);
    chk("t1_wdata", wd_at(0), 8);
    chk("t1_mem", mem[1], 8);
    chk("t1_upd", updates_done, 1);
    chk("t1_cyc", cycles, 7);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    repeat (3) @(negedge clk);
    chk("t1_cyc_hold", cycles, 7);
    chk("t1_upd_hold", updates_done, 1);
    chk("t1_busy_idle", busy, 0);
    // zero seed behaves as seed 1; second LFSR value masks to 0
    mem[1] = 7; mem[0] = 64'h10;
    run(64'h0, 2, 32'hFF, 0, 100);
    chk("t2_rd0", rd_at(0), 1);
    chk("t2_rd1", rd_at(1), 0);
    chk("t2_mem1", mem[1], 8);
    chk("t2_mem0", mem[0], 64'h11);
    chk("t2_upd", updates_done, 2);
    chk("t2_done_at", done_at, 11);
    // zero updates: no access, done three cycles after start
    run(64'h5, 0, 32'hFF, 0, 100);
    chk("t3_no_req", 64'(first_req < 0), 1);
    chk("t3_done_at", done_at, 3);
    chk("t3_cyc", cycles, 3);
    chk("t3_upd", updates_done, 0);
    // XOR mode and INC wrap
    mem[1] = '1;
    run(64'h1, 1, 32'hFF, 1, 100);
    chk("t4_xor", wd_at(0), 64'hFFFF_FFFF_FFFF_FFFE);
    mem[1] = '1;
    run(64'h1, 1, 32'hFF, 0, 100);
    chk("t4_wrap", wd_at(0), 0);
    // range_mask 0: every access hits address 0
    mem[0] = 100;
    run(64'h7, 3, 32'h0, 0, 100);
    sum = 0;
    foreach (rd_log[i]) sum += rd_log[i];
    foreach (wa_log[i]) sum += wa_log[i];
    chk("t4_mask0_addr", sum, 0);
    chk("t4_mask0_nwr", wa_log.size(), 3);
    chk("t4_mask0_mem", mem[0], 103);
    // random stalls against a reference GUPS model
    max_stall = 5;
    for (int md = 0; md < 2; md++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = {32'(i * 3 + md), 32'hA5A5_0000 + 32'(i)};
        ref_mem[i] = mem[i];
      end
      l = 64'h0123_4567_89AB_CDEF;
      for (int i = 0; i < 300; i++) begin
        ref_mem[l[7:0]] = md[0] ? (ref_mem[l[7:0]] ^ l) : (ref_mem[l[7:0]] + 1);
        l = step(l);
      end
      stab_err = 0;
      run(64'h0123_4567_89AB_CDEF, 300, 32'hFF, md[0], 20000);
      mis = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mis++;
      chk("t5_upd", updates_done, 300);
      chk("t5_nwr", wa_log.size(), 300);
      chk("t5_mem_mismatch", mis, 0);
      chk("t5_stable", stab_err, 0);
      chk("t5_range", hi_seen, 0);
    end
    max_stall = 0;
    // reset during a stalled write
    hold_wr = 1;
    wa_log.delete();
    mem[1] = 7;
    @(negedge clk);
    seed = 64'h1; num_updates = 5; range_mask = 32'hFF; mode = 0; start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 50 && !(mem_req && mem_we); k++) @(negedge clk);
    chk("t6_in_wr", 64'(mem_req && mem_we), 1);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("t6_req", mem_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_upd", updates_done, 0);
    chk("t6_cyc", cycles, 0);
    chk("t6_nwr", wa_log.size(), 0);
    chk("t6_mem", mem[1], 7);
    reset = 1;
    hold_wr = 0;
    run(64'h1, 1, 32'hFF, 0, 100);
    chk("t6_rerun_upd", updates_done, 1);
    chk("t6_rerun_mem", mem[1], 8);
    chk("t6_rerun_done_at", done_at, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
